rob_multi_retire: RTL and testbench
===================================

Name: rob_multi_retire

Overview:
Parametrised successor to the single-port ROB/retire stage. It allocates entries in program order and returns a tag per entry. Out-of-order completions mark entries done. Up to RETIRE_WIDTH done entries retire in order per cycle, driving R-RAT updates and returning old physical registers to the free list. It supports precise exceptions and a global flush, and sits between rename/dispatch and the R-RAT/free list.

Parameters:
SIZE, 64, entry count; must be a power of two and ≥ 2*RETIRE_WIDTH
NUM_ARCH_REGS, 32, architectural registers; LA = $clog2(NUM_ARCH_REGS)
NUM_PHYS_REGS, 64, physical registers; LP = $clog2(NUM_PHYS_REGS)
RETIRE_WIDTH, 2, maximum retirements per cycle
TW, $clog2(SIZE), tag width (derived localparam)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
Dispatch_valid_IN  in  1  allocate one entry this cycle
Dispatch_has_dest_IN  in  1  entry writes a register
Dispatch_arch_IN  in  LA  destination architectural register
Dispatch_phys_IN  in  LP  newly mapped physical register
Dispatch_old_phys_IN  in  LP  previous mapping, freed at retire
Dispatch_tag_OUT  out  TW  tag that will be assigned if dispatch is accepted (current tail)
Full  out  1  no free entry; dispatch ignored
Empty  out  1  no valid entries
Count_OUT  out  TW+1  occupied entries
Complete_valid_IN  in  1  an execution unit finished an entry
Complete_tag_IN  in  TW  tag of the finished entry
Complete_exc_IN  in  1  the finished entry raised an exception
Flush_IN  in  1  discard all entries
Retire_valid_OUT  out  RETIRE_WIDTH  per-slot retire strobe; slot 0 is oldest
Retire_regupd_OUT  out  RETIRE_WIDTH  slot updates the R-RAT (valid & has_dest)
Retire_arch_OUT  out  RETIRE_WIDTH*LA  packed architectural register, slot i at [i*LA +: LA]
Retire_phys_OUT  out  RETIRE_WIDTH*LP  packed new physical register
Retire_old_phys_OUT  out  RETIRE_WIDTH*LP  packed physical register to free
Exception_OUT  out  1  one-cycle pulse: precise exception at head
Exception_tag_OUT  out  TW  tag of the excepting entry

Behaviour:
- Storage: per entry valid, done, exc, has_dest, arch, phys, old_phys. Head and tail are TW+1 bits; the extra bit is the wrap bit. Full when the low bits are equal and the wrap bits differ; Empty when the pointers are equal. Full, Empty and Count_OUT are registered state.
- Reset, or Flush_IN at the clock edge: head=tail=0, all valid=0. Next cycle all Retire_* and Exception_* outputs are 0, Empty=1, Full=0, Count_OUT=0.
- Priority each cycle: RESET > Flush_IN > exception > normal update.
- Dispatch: accepted when Dispatch_valid_IN & !Full. Write the entry at tail with done=0, then tail+1 (wraps naturally). Dispatch_valid_IN while Full is dropped with no state change. Full is evaluated before same-cycle retirement frees space.
- Completion: when Complete_valid_IN, set done=1 and exc=Complete_exc_IN for the entry at that tag if it is valid; otherwise ignore. A completion becomes visible to retire next cycle.
- Retire, evaluated on registered state with latency 1 (outputs registered):
  - Slot i retires iff entry head+i is valid, done and !exc, and every slot j<i retires.
  - Retired entries are cleared and head advances by the number retired (0..RETIRE_WIDTH).
  - Retire_* outputs reflect those entries in the following cycle only.
- Exception: if the first non-retiring entry within the group is valid, done and exc:
  - Older slots still retire this cycle.
  - Exception_OUT=1 and Exception_tag_OUT=that tag for one cycle.
  - The whole buffer is cleared, as for a flush, in the same edge.
- Simultaneous dispatch, complete and retire in one cycle are all legal. Count_OUT = old + accepted − retired.

Optional Feature:
ROB_STATS_EN. When defined, add outputs Stat_retired_OUT [31:0], Stat_full_cycles_OUT [31:0] and Stat_exc_OUT [15:0]. These are saturating counters of retired instructions, cycles with Full & Dispatch_valid_IN, and exceptions. They clear on RESET only and are unaffected by Flush_IN. When undefined, the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Package rob_pkg holds ROB entry struct/field widths (LA, LP, TW), default parameter constants, and the pointer-to-count function.
- Sub-module rob_retire_select: combinational; it takes RETIRE_WIDTH window entries from the head and produces per-slot retire mask, retire count and exception hit/slot.

Test Plan:
- Reset, then dispatch 3 entries (arch 1/2/3, phys 33/34/35) and complete tags 2,1,0 on successive cycles → no retire until tag0 done. Next cycle retire slots 0,1 (arch 1,2). Following cycle slot 0 (arch 3); Empty=1.
- Dispatch 64 entries without completing → Full=1 after the 64th and Count_OUT=64. A 65th dispatch is ignored and tail is unchanged. Complete all; retire 2 per cycle for 32 cycles; head wraps to 0.
- Entries 0..3 all done, entry 1 with exc=1 → slot 0 retires. Exception_OUT=1 with Exception_tag_OUT=1 for one cycle, then Empty=1. Entries 2,3 never retire.
- Flush_IN asserted in the same cycle as dispatch and completion → next cycle Empty=1, no Retire_valid_OUT, and the dispatch is discarded.
- has_dest=0 entry retires → Retire_valid_OUT[0]=1, Retire_regupd_OUT[0]=0.
- Complete_valid_IN to an unallocated tag → no state change; RESET mid-stream → all outputs 0 the next cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared ROB defaults, per-entry flag struct and pointer-to-count helper
package rob_pkg;
  localparam int DEF_SIZE = 64;
  localparam int DEF_ARCH_REGS = 32;
  localparam int DEF_PHYS_REGS = 64;
  localparam int DEF_RETIRE_WIDTH = 2;
  typedef struct packed {
    logic valid;
    logic done;
    logic exc;
    logic has_dest;
  } rob_flags_t;
  function automatic int unsigned ptr_count(input int unsigned head, input int unsigned tail, input int unsigned tw);
    return (tail - head) & ((32'd1 << (tw + 1)) - 32'd1);
  endfunction
endpackage

// File: rtl/rob_retire_select.sv
// rob_retire_select: in-order retire mask, count and exception slot over the head window
// Ports: win_i (flags of RW entries from head, slot 0 oldest) -> mask_o, cnt_o, exc_hit_o, exc_slot_o
module rob_retire_select
  import rob_pkg::*;
#(
  parameter int RW = DEF_RETIRE_WIDTH,
  localparam int CW = $clog2(RW + 1),
  localparam int SW = RW > 1 ? $clog2(RW) : 1
) (
  input  rob_flags_t       win_i [RW],
  output logic [RW-1:0]    mask_o,
  output logic [CW-1:0]    cnt_o,
  output logic             exc_hit_o,
  output logic [SW-1:0]    exc_slot_o
);
  logic go, ok;
  always_comb begin
    mask_o = '0;
    cnt_o = '0;
    exc_hit_o = 1'b0;
    exc_slot_o = '0;
    go = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < RW; i++) begin
      ok = win_i[i].valid & win_i[i].done & ~win_i[i].exc;
      if (go && ok) begin
        mask_o[i] = 1'b1;
        cnt_o = cnt_o + CW'(1);
      end else if (go) begin
        exc_hit_o = win_i[i].valid & win_i[i].done;
        exc_slot_o = SW'(i);
        go = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rob_multi_retire.sv
// rob_multi_retire: reorder buffer with in-order multi-slot retire, precise exceptions and flush
// Ports: CLK/RESET; Dispatch_* allocate at tail (Dispatch_tag_OUT, Full, Empty, Count_OUT);
// Complete_* mark entries done; Flush_IN clears; Retire_* / Exception_* are registered results.
// Optional: define ROB_STATS_EN for Stat_retired_OUT, Stat_full_cycles_OUT, Stat_exc_OUT.
module rob_multi_retire
  import rob_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int NUM_ARCH_REGS = DEF_ARCH_REGS,
  parameter int NUM_PHYS_REGS = DEF_PHYS_REGS,
  parameter int RETIRE_WIDTH = DEF_RETIRE_WIDTH,
  localparam int LA = $clog2(NUM_ARCH_REGS),
  localparam int LP = $clog2(NUM_PHYS_REGS),
  localparam int TW = $clog2(SIZE),
  localparam int RW = RETIRE_WIDTH,
  localparam int CW = $clog2(RW + 1),
  localparam int SW = RW > 1 ? $clog2(RW) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Dispatch_valid_IN,
  input  logic                 Dispatch_has_dest_IN,
  input  logic [LA-1:0]        Dispatch_arch_IN,
  input  logic [LP-1:0]        Dispatch_phys_IN,
  input  logic [LP-1:0]        Dispatch_old_phys_IN,
  output logic [TW-1:0]        Dispatch_tag_OUT,
  output logic                 Full,
  output logic                 Empty,
  output logic [TW:0]          Count_OUT,
  input  logic                 Complete_valid_IN,
  input  logic [TW-1:0]        Complete_tag_IN,
  input  logic                 Complete_exc_IN,
  input  logic                 Flush_IN,
  output logic [RW-1:0]        Retire_valid_OUT,
  output logic [RW-1:0]        Retire_regupd_OUT,
  output logic [RW*LA-1:0]     Retire_arch_OUT,
  output logic [RW*LP-1:0]     Retire_phys_OUT,
  output logic [RW*LP-1:0]     Retire_old_phys_OUT,
  output logic                 Exception_OUT,
  output logic [TW-1:0]        Exception_tag_OUT
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]          Stat_retired_OUT,
  output logic [31:0]          Stat_full_cycles_OUT,
  output logic [15:0]          Stat_exc_OUT
`endif
);
  rob_flags_t fl_q [SIZE];
  rob_flags_t fl_d [SIZE];
  logic [LA-1:0] arch_q [SIZE];
  logic [LP-1:0] phys_q [SIZE];
  logic [LP-1:0] old_q [SIZE];
  logic [TW:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, accept;
  logic [TW-1:0] widx [RW];
  rob_flags_t win [RW];
  logic [RW-1:0] mask, rv_q, rv_d, ru_q, ru_d;
  logic [CW-1:0] cnt;
  logic exc_hit, exc_q, exc_d;
  logic [SW-1:0] exc_slot;
  logic [TW-1:0] etag_q, etag_d;
  logic [RW*LA-1:0] ra_q, ra_d;
  logic [RW*LP-1:0] rp_q, rp_d, ro_q, ro_d;
  always_comb
    for (int i = 0; i < RW; i++) begin
      widx[i] = head_q[TW-1:0] + TW'(i);
      win[i] = fl_q[widx[i]];
    end
  rob_retire_select #(.RW(RW)) u_sel (
    .win_i(win),
    .mask_o(mask),
    .cnt_o(cnt),
    .exc_hit_o(exc_hit),
    .exc_slot_o(exc_slot)
  );
  assign accept = Dispatch_valid_IN & ~full_q;
  always_comb begin
    fl_d = fl_q;
    head_d = head_q;
    tail_d = tail_q;
    exc_d = 1'b0;
    etag_d = '0;
    for (int i = 0; i < RW; i++) begin
      rv_d[i] = mask[i];
      ru_d[i] = mask[i] & win[i].has_dest;
      ra_d[i*LA +: LA] = mask[i] ? arch_q[widx[i]] : '0;
      rp_d[i*LP +: LP] = mask[i] ? phys_q[widx[i]] : '0;
      ro_d[i*LP +: LP] = mask[i] ? old_q[widx[i]] : '0;
    end
    if (Flush_IN) begin
      fl_d = '{default: '0};
      head_d = '0;
      tail_d = '0;
      rv_d = '0;
      ru_d = '0;
      ra_d = '0;
      rp_d = '0;
      ro_d = '0;
    end else if (exc_hit) begin
      fl_d = '{default: '0};
      head_d = '0;
      tail_d = '0;
      exc_d = 1'b1;
      etag_d = widx[exc_slot];
    end else begin
      if (Complete_valid_IN && fl_q[Complete_tag_IN].valid) begin
        fl_d[Complete_tag_IN].done = 1'b1;
        fl_d[Complete_tag_IN].exc = Complete_exc_IN;
      end
      if (accept)
        fl_d[tail_q[TW-1:0]] = '{valid: 1'b1, done: 1'b0, exc: 1'b0, has_dest: Dispatch_has_dest_IN};
      for (int i = 0; i < RW; i++)
        if (mask[i]) fl_d[widx[i]] = '0;
      head_d = head_q + (TW+1)'(cnt);
      tail_d = tail_q + (TW+1)'(accept);
    end
    count_d = (TW+1)'(ptr_count(32'(head_d), 32'(tail_d), TW));
    full_d = (head_d[TW-1:0] == tail_d[TW-1:0]) && (head_d[TW] != tail_d[TW]);
    empty_d = head_d == tail_d;
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      fl_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      rv_q <= '0;
      ru_q <= '0;
      ra_q <= '0;
      rp_q <= '0;
      ro_q <= '0;
      exc_q <= 1'b0;
      etag_q <= '0;
    end else begin
      fl_q <= fl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      rv_q <= rv_d;
      ru_q <= ru_d;
      ra_q <= ra_d;
      rp_q <= rp_d;
      ro_q <= ro_d;
      exc_q <= exc_d;
      etag_q <= etag_d;
    end
  // payload needs no reset: it is only read through a valid entry
  always_ff @(posedge CLK)
    if (accept) begin
      arch_q[tail_q[TW-1:0]] <= Dispatch_arch_IN;
      phys_q[tail_q[TW-1:0]] <= Dispatch_phys_IN;
      old_q[tail_q[TW-1:0]] <= Dispatch_old_phys_IN;
    end
  assign Dispatch_tag_OUT = tail_q[TW-1:0];
  assign Full = full_q;
  assign Empty = empty_q;
  assign Count_OUT = count_q;
  assign Retire_valid_OUT = rv_q;
  assign Retire_regupd_OUT = ru_q;
  assign Retire_arch_OUT = ra_q;
  assign Retire_phys_OUT = rp_q;
  assign Retire_old_phys_OUT = ro_q;
  assign Exception_OUT = exc_q;
  assign Exception_tag_OUT = etag_q;
`ifdef ROB_STATS_EN
  logic [CW-1:0] rcnt;
  assign rcnt = Flush_IN ? '0 : cnt;
  always_ff @(posedge CLK)
    if (RESET) begin
      Stat_retired_OUT <= '0;
      Stat_full_cycles_OUT <= '0;
      Stat_exc_OUT <= '0;
    end else begin
      Stat_retired_OUT <= (Stat_retired_OUT > ~32'(rcnt)) ? '1 : Stat_retired_OUT + 32'(rcnt);
      if (full_q && Dispatch_valid_IN && !(&Stat_full_cycles_OUT))
        Stat_full_cycles_OUT <= Stat_full_cycles_OUT + 32'd1;
      if (exc_hit && !Flush_IN && !(&Stat_exc_OUT))
        Stat_exc_OUT <= Stat_exc_OUT + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rob_multi_retire.sv
// tb_rob_multi_retire: directed plus random checks of rob_multi_retire against a queue-based model
module tb_rob_multi_retire;
  localparam int SIZE = 64;
  localparam int RW = 2;
  localparam int LA = 5;
  localparam int LP = 6;
  localparam int TW = 6;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic Dispatch_valid_IN = 1'b0, Dispatch_has_dest_IN = 1'b0;
  logic [LA-1:0] Dispatch_arch_IN = '0;
  logic [LP-1:0] Dispatch_phys_IN = '0, Dispatch_old_phys_IN = '0;
  logic [TW-1:0] Dispatch_tag_OUT;
  logic Full, Empty;
  logic [TW:0] Count_OUT;
  logic Complete_valid_IN = 1'b0, Complete_exc_IN = 1'b0, Flush_IN = 1'b0;
  logic [TW-1:0] Complete_tag_IN = '0;
  logic [RW-1:0] Retire_valid_OUT, Retire_regupd_OUT;
  logic [RW*LA-1:0] Retire_arch_OUT;
  logic [RW*LP-1:0] Retire_phys_OUT, Retire_old_phys_OUT;
  logic Exception_OUT;
  logic [TW-1:0] Exception_tag_OUT;
  always #5 CLK = ~CLK;
  rob_multi_retire dut (
    .CLK(CLK), .RESET(RESET),
    .Dispatch_valid_IN(Dispatch_valid_IN), .Dispatch_has_dest_IN(Dispatch_has_dest_IN),
    .Dispatch_arch_IN(Dispatch_arch_IN), .Dispatch_phys_IN(Dispatch_phys_IN),
    .Dispatch_old_phys_IN(Dispatch_old_phys_IN), .Dispatch_tag_OUT(Dispatch_tag_OUT),
    .Full(Full), .Empty(Empty), .Count_OUT(Count_OUT),
    .Complete_valid_IN(Complete_valid_IN), .Complete_tag_IN(Complete_tag_IN),
    .Complete_exc_IN(Complete_exc_IN), .Flush_IN(Flush_IN),
    .Retire_valid_OUT(Retire_valid_OUT), .Retire_regupd_OUT(Retire_regupd_OUT),
    .Retire_arch_OUT(Retire_arch_OUT), .Retire_phys_OUT(Retire_phys_OUT),
    .Retire_old_phys_OUT(Retire_old_phys_OUT),
    .Exception_OUT(Exception_OUT), .Exception_tag_OUT(Exception_tag_OUT)
  );
  typedef struct {
    bit hd;
    int arch, phys, old;
    bit done, exc;
    int tag;
  } ent_t;
  ent_t q[$];
  int tail_tag;
  logic [RW-1:0] e_rv, e_ru;
  logic [RW*LA-1:0] e_ra;
  logic [RW*LP-1:0] e_rp, e_ro;
  logic e_exc;
  logic [TW-1:0] e_etag;
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_edge();
    int nr;
    bit ex;
    int et;
    e_rv = '0; e_ru = '0; e_ra = '0; e_rp = '0; e_ro = '0; e_exc = 1'b0; e_etag = '0;
    nr = 0; ex = 0; et = 0;
    for (int i = 0; i < RW && i < q.size(); i++) begin
      if (q[i].done && !q[i].exc) begin
        e_rv[i] = 1'b1;
        e_ru[i] = q[i].hd;
        e_ra[i*LA +: LA] = LA'(q[i].arch);
        e_rp[i*LP +: LP] = LP'(q[i].phys);
        e_ro[i*LP +: LP] = LP'(q[i].old);
        nr++;
      end else begin
        if (q[i].done) begin ex = 1; et = q[i].tag; end
        break;
      end
    end
    if (RESET || Flush_IN) begin
      e_rv = '0; e_ru = '0; e_ra = '0; e_rp = '0; e_ro = '0;
      q.delete();
      tail_tag = 0;
    end else if (ex) begin
      e_exc = 1'b1;
      e_etag = TW'(et);
      q.delete();
      tail_tag = 0;
    end else begin
      if (Complete_valid_IN)
        foreach (q[k]) if (q[k].tag == int'(Complete_tag_IN)) begin
          q[k].done = 1;
          q[k].exc = Complete_exc_IN;
        end
      if (Dispatch_valid_IN && q.size() < SIZE) begin
        q.push_back('{hd: Dispatch_has_dest_IN, arch: int'(Dispatch_arch_IN), phys: int'(Dispatch_phys_IN),
                      old: int'(Dispatch_old_phys_IN), done: 0, exc: 0, tag: tail_tag});
        tail_tag = (tail_tag + 1) % SIZE;
      end
      repeat (nr) void'(q.pop_front());
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    chk("retire_valid", Retire_valid_OUT, e_rv);
    chk("retire_regupd", Retire_regupd_OUT, e_ru);
    chk("retire_arch", Retire_arch_OUT, e_ra);
    chk("retire_phys", Retire_phys_OUT, e_rp);
    chk("retire_old", Retire_old_phys_OUT, e_ro);
    chk("exception", Exception_OUT, e_exc);
    chk("exception_tag", Exception_tag_OUT, e_etag);
    chk("full", Full, q.size() == SIZE);
    chk("empty", Empty, q.size() == 0);
    chk("count", Count_OUT, q.size());
    chk("dispatch_tag", Dispatch_tag_OUT, tail_tag);
    RESET = 1'b0; Flush_IN = 1'b0;
    Dispatch_valid_IN = 1'b0; Complete_valid_IN = 1'b0; Complete_exc_IN = 1'b0;
  endtask
  task automatic disp(input int hd, input int a, input int p, input int o);
    Dispatch_valid_IN = 1'b1;
    Dispatch_has_dest_IN = hd[0];
    Dispatch_arch_IN = LA'(a);
    Dispatch_phys_IN = LP'(p);
    Dispatch_old_phys_IN = LP'(o);
  endtask
  task automatic comp(input int t, input bit e);
    Complete_valid_IN = 1'b1;
    Complete_tag_IN = TW'(t);
    Complete_exc_IN = e;
  endtask
  initial begin
    int pd, pc;
    tail_tag = 0;
    cyc();
    cyc();
    disp(1, 1, 33, 1); cyc();
    disp(1, 2, 34, 2); cyc();
    disp(1, 3, 35, 3); cyc();
    comp(2, 0); cyc();
    comp(1, 0); cyc();
    chk("t1_wait", Retire_valid_OUT, 0);
    comp(0, 0); cyc();
    cyc();
    chk("t1_pair", Retire_valid_OUT, 2'b11);
    chk("t1_pair_arch", Retire_arch_OUT, {5'd2, 5'd1});
    cyc();
    chk("t1_last_valid", Retire_valid_OUT, 2'b01);
    chk("t1_last_arch", Retire_arch_OUT, 3);
    chk("t1_empty", Empty, 1);
    for (int i = 0; i < SIZE; i++) begin
      disp(1, i % 32, i, (i + 7) % 64);
      cyc();
    end
    chk("fill_full", Full, 1);
    chk("fill_count", Count_OUT, 64);
    disp(1, 9, 9, 9); cyc();
    chk("overflow_tag", Dispatch_tag_OUT, 3);
    chk("overflow_count", Count_OUT, 64);
    for (int t = 0; t < SIZE; t++) begin
      comp(t, 0);
      cyc();
    end
    repeat (40) cyc();
    chk("drain_empty", Empty, 1);
    RESET = 1'b1; cyc();
    for (int i = 0; i < 4; i++) begin
      disp(1, 10 + i, 20 + i, 30 + i);
      cyc();
    end
    comp(2, 0); cyc();
    comp(3, 0); cyc();
    comp(1, 1); cyc();
    comp(0, 0); cyc();
    cyc();
    chk("exc_pulse", Exception_OUT, 1);
    chk("exc_tag", Exception_tag_OUT, 1);
    chk("exc_older_retire", Retire_valid_OUT, 2'b01);
    cyc();
    chk("exc_one_cycle", Exception_OUT, 0);
    chk("exc_empty", Empty, 1);
    chk("exc_no_younger", Retire_valid_OUT, 0);
    disp(1, 4, 4, 4); cyc();
    disp(1, 5, 5, 5); cyc();
    disp(1, 6, 6, 6); comp(0, 0); Flush_IN = 1'b1; cyc();
    chk("flush_empty", Empty, 1);
    chk("flush_count", Count_OUT, 0);
    cyc();
    chk("flush_no_retire", Retire_valid_OUT, 0);
    disp(0, 7, 40, 41); cyc();
    comp(0, 0); cyc();
    cyc();
    chk("nodest_valid", Retire_valid_OUT, 2'b01);
    chk("nodest_regupd", Retire_regupd_OUT, 0);
    comp(20, 0); cyc();
    chk("stray_count", Count_OUT, 0);
    disp(1, 8, 8, 8); cyc();
    comp(5, 1); cyc();
    cyc();
    chk("stray_no_exc", Exception_OUT, 0);
    chk("stray_count1", Count_OUT, 1);
    disp(1, 9, 9, 9); RESET = 1'b1; cyc();
    chk("midreset_count", Count_OUT, 0);
    chk("midreset_empty", Empty, 1);
    for (int n = 0; n < 3000; n++) begin
      pd = n < 1500 ? 8 : 4;
      pc = n < 1500 ? 4 : 8;
      if ($urandom_range(0, 9) < pd)
        disp($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      if ($urandom_range(0, 9) < pc) begin
        if (q.size() > 0 && $urandom_range(0, 9) < 8)
          comp(q[$urandom_range(0, q.size() - 1)].tag, $urandom_range(0, 29) == 0);
        else
          comp($urandom_range(0, SIZE - 1), $urandom_range(0, 29) == 0);
      end
      Flush_IN = $urandom_range(0, 299) == 0;
      RESET = $urandom_range(0, 599) == 0;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
